rv_decode_mt: RTL and testbench
===============================

Name: rv_decode_mt

Overview:
Registered, thread-tagged RV32I decode stage for the multi-threaded core. It accepts raw instructions with a thread ID and PC over a valid/ready handshake. It produces register-field, enable and control outputs plus a sign-extended immediate and an illegal-instruction flag. A 2-entry output buffer sustains one instruction per cycle under backpressure, and per-thread flush drops buffered instructions of a killed thread.

Parameters:
NTHREADS, 4, number of hardware threads (≥2)
TID_W, $clog2(NTHREADS), thread ID width
XLEN, 32, PC and immediate width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  stage can accept
in_inst  in  32  raw instruction
in_tid  in  TID_W  thread ID
in_pc  in  XLEN  instruction PC
flush_valid  in  1  kill request
flush_tid  in  TID_W  thread to kill
out_valid  out  1  decoded entry available
out_ready  in  1  consumer accepts
out_tid / out_pc  out  TID_W / XLEN  passthrough
out_opcode  out  7  inst[6:0]
out_rs1 / out_rs2 / out_rd  out  5 each  register fields
out_rs1_en / out_rs2_en / out_rd_en  out  1 each  field used
out_funct3 / out_f3_en  out  3 / 1  funct3 and its valid
out_funct7 / out_f7_en  out  7 / 1  funct7 and its valid
out_imm  out  XLEN  sign-extended immediate, 0 if none
out_mem_en / out_mem_wr  out  1 each  load/store, store
out_csr_en / out_csr_wr  out  1 each  CSR access, CSR write
out_pc_load  out  1  control transfer
out_illegal  out  1  illegal encoding

Behaviour:
- Reset is asynchronous and active-low.
- Reset values: buffer empty, out_valid=0, in_ready=1, all out_* fields 0.
- Decode is combinational on in_inst. The result is written into the buffer on accept, where accept = in_valid & in_ready.
- Latency: an instruction accepted at edge N is presented at the output after edge N. Throughput is 1/cycle.
- Buffer: 2-entry FIFO. in_ready=(count<2), registered from count. Pop = out_valid & out_ready. Push and pop in the same cycle leave count unchanged. The head is always presented; order is preserved.
- out_valid and all payload outputs stay stable while out_valid=1 & out_ready=0.
- Decode table (inst[1:0] must be 11, else illegal):
  - LUI/AUIPC: rd; U-imm.
  - JAL: rd, pc_load; J-imm.
  - JALR (f3=000): rs1, rd, f3, pc_load; I-imm.
  - BRANCH (f3≠010,011): rs1, rs2, f3, pc_load; B-imm.
  - LOAD (f3∈{000,001,010,100,101}): rs1, rd, f3, mem_en; I-imm.
  - STORE (f3≤010): rs1, rs2, f3, mem_en, mem_wr; S-imm.
  - OP-IMM: rs1, rd, f3; I-imm. For f3=001/101, f7_en=1 and imm=shamt; funct7 must be 0000000, or 0100000 only when f3=101.
  - OP: rs1, rs2, rd, f3, f7. funct7=0000000, or 0100000 only for f3∈{000,101}.
  - SYSTEM f3∉{000,100}: rd, f3, csr_en. rs1_en=~f3[2]. For f3[2]=1, imm=zero-extended rs1 field. csr_wr=0 only when f3[1]=1 and the rs1 field is 0, else 1.
  - SYSTEM f3=000: legal only for 0x00000073 and 0x00100073, with no enables.
  - MISC-MEM: legal, no enables.
  - Any other opcode: illegal.
- Illegal: out_illegal=1; all *_en, mem_*, csr_*, pc_load and imm forced to 0. Fields are still passed through.
- rd_en is forced to 0 when rd=x0.
- Flush: when flush_valid=1, every buffered entry with tid==flush_tid is removed at the edge and remaining entries compact toward the head. An instruction accepted in the same cycle with in_tid==flush_tid is discarded. A pop of a matching head in that cycle counts as consumed, not double-removed.
- Flush of a non-matching tid has no effect. Flush while the buffer is empty has no effect.
- Reset mid-operation immediately empties the buffer and drops outputs to reset values.

Test Plan:
1. in=0x000050b7, tid=1, out_ready=1 → next cycle: out_valid=1, opcode=0110111, rd=1, rd_en=1, imm=0x00005000, tid=1, other enables 0.
2. Back-to-back 0x00508193, 0x00502083, 0xfe000ce3, 0xff9ff2ef → 4 consecutive outputs:
   - rs1=1, rd=3, imm=5;
   - lw: mem_en=1, mem_wr=0, rd=1, imm=5;
   - beq: rs1_en=rs2_en=pc_load=1, rd_en=0, imm=0xFFFFFFF8;
   - jal: rd=5, pc_load=1, imm=0xFFFFFFF8.
3. out_ready=0, push 3 instructions → in_ready=0 after 2 accepts, third held. The head is stable over 5 cycles, then out_ready=1 drains in order.
4. Buffer holds tid0 then tid2, flush_tid=0 while pushing tid0 → tid0 entry and the incoming tid0 dropped; next out is tid2, count=1.
5. 0x00000000, 0x0000f033 (OP f3=111, f7=0: legal), 0x4000f033 (illegal f7), 0x00001073 (csrrw x0,0,x0: csr_wr=1, rd_en=0), 0x00002073 (csrrs rs1=0: csr_wr=0) → illegal=1, 0, 1, 0, 0.
6. rst_n low with 2 buffered entries → out_valid=0, in_ready=1 asynchronously; after release the first new push appears 1 cycle later.

Source files
------------

// File: rtl/rv_decode_mt.sv
// rv_decode_mt: registered, thread-tagged RV32I decode stage.
//
// An instruction with its thread ID and PC is accepted on in_valid & in_ready.
// It is decoded combinationally and written into a 2-entry output FIFO. The
// FIFO head drives every out_* port. flush_valid/flush_tid removes all
// buffered entries of one thread, and also an instruction of that thread
// accepted in the same cycle. Surviving entries keep their order.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready = buffer not full)
//   in_inst/in_tid/in_pc    raw instruction, thread ID, PC
//   flush_valid/flush_tid   per-thread kill request
//   out_valid/out_ready     output handshake
//   out_tid/out_pc          passthrough of the head entry
//   out_opcode..out_funct7  raw instruction fields with per-field use flags
//   out_imm                 sign-extended immediate, 0 if none or illegal
//   out_mem_*/out_csr_*     load/store and CSR controls
//   out_pc_load             control transfer
//   out_illegal             illegal encoding
module rv_decode_mt #(
    parameter int NTHREADS = 4,
    parameter int TID_W    = $clog2(NTHREADS),
    parameter int XLEN     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TID_W-1:0] in_tid,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush_valid,
    input  logic [TID_W-1:0] flush_tid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TID_W-1:0] out_tid,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_rs1_en,
    output logic             out_rs2_en,
    output logic             out_rd_en,
    output logic [2:0]       out_funct3,
    output logic             out_f3_en,
    output logic [6:0]       out_funct7,
    output logic             out_f7_en,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_mem_en,
    output logic             out_mem_wr,
    output logic             out_csr_en,
    output logic             out_csr_wr,
    output logic             out_pc_load,
    output logic             out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_en;
        logic [2:0]      funct3;
        logic            f3_en;
        logic [6:0]      funct7;
        logic            f7_en;
        logic [XLEN-1:0] imm;
        logic            mem_en;
        logic            mem_wr;
        logic            csr_en;
        logic            csr_wr;
        logic            pc_load;
        logic            illegal;
    } dec_t;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [XLEN-1:0]  pc;
        dec_t             dec;
    } entry_t;

    // ---------------------------------------------------------------- decode
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
    logic        w_legal;
    dec_t        w_dec;

    assign w_f3    = in_inst[14:12];
    assign w_f7    = in_inst[31:25];
    assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u = {in_inst[31:12], 12'b0};
    assign w_imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_dec        = '0;
        w_legal      = 1'b0;
        w_imm32      = '0;
        w_dec.opcode = in_inst[6:0];
        w_dec.rs1    = in_inst[19:15];
        w_dec.rs2    = in_inst[24:20];
        w_dec.rd     = in_inst[11:7];
        w_dec.funct3 = w_f3;
        w_dec.funct7 = w_f7;

        case (in_inst[6:0])
            OP_LUI, OP_AUIPC: begin
                w_legal      = 1'b1;
                w_dec.rd_en  = 1'b1;
                w_imm32      = w_imm_u;
            end
            OP_JAL: begin
                w_legal       = 1'b1;
                w_dec.rd_en   = 1'b1;
                w_dec.pc_load = 1'b1;
                w_imm32       = w_imm_j;
            end
            OP_JALR: begin
                w_legal       = (w_f3 == 3'b000);
                w_dec.rs1_en  = 1'b1;
                w_dec.rd_en   = 1'b1;
                w_dec.f3_en   = 1'b1;
                w_dec.pc_load = 1'b1;
                w_imm32       = w_imm_i;
            end
            OP_BRANCH: begin
                w_legal       = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_dec.rs1_en  = 1'b1;
                w_dec.rs2_en  = 1'b1;
                w_dec.f3_en   = 1'b1;
                w_dec.pc_load = 1'b1;
                w_imm32       = w_imm_b;
            end
            OP_LOAD: begin
                w_legal      = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                w_dec.rs1_en = 1'b1;
                w_dec.rd_en  = 1'b1;
                w_dec.f3_en  = 1'b1;
                w_dec.mem_en = 1'b1;
                w_imm32      = w_imm_i;
            end
            OP_STORE: begin
                w_legal      = (w_f3 <= 3'b010);
                w_dec.rs1_en = 1'b1;
                w_dec.rs2_en = 1'b1;
                w_dec.f3_en  = 1'b1;
                w_dec.mem_en = 1'b1;
                w_dec.mem_wr = 1'b1;
                w_imm32      = w_imm_s;
            end
            OP_IMM: begin
                w_dec.rs1_en = 1'b1;
                w_dec.rd_en  = 1'b1;
                w_dec.f3_en  = 1'b1;
                // Shifts carry funct7 and a 5-bit shamt instead of an I-imm.
                if (w_f3[1:0] == 2'b01) begin
                    w_dec.f7_en = 1'b1;
                    w_imm32     = {27'b0, in_inst[24:20]};
                    w_legal     = (w_f7 == 7'b0) || (w_f3[2] && w_f7 == F7_ALT);
                end else begin
                    w_legal     = 1'b1;
                    w_imm32     = w_imm_i;
                end
            end
            OP_OP: begin
                w_dec.rs1_en = 1'b1;
                w_dec.rs2_en = 1'b1;
                w_dec.rd_en  = 1'b1;
                w_dec.f3_en  = 1'b1;
                w_dec.f7_en  = 1'b1;
                w_legal      = (w_f7 == 7'b0) ||
                               (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101));
            end
            OP_SYSTEM: begin
                if (w_f3 == 3'b000) begin
                    // Only ECALL and EBREAK are recognised.
                    w_legal = (in_inst == 32'h0000_0073) || (in_inst == 32'h0010_0073);
                end else if (w_f3 != 3'b100) begin
                    w_legal      = 1'b1;
                    w_dec.rd_en  = 1'b1;
                    w_dec.f3_en  = 1'b1;
                    w_dec.csr_en = 1'b1;
                    w_dec.rs1_en = ~w_f3[2];
                    // CSRRS/CSRRC(I) with a zero source only read the CSR.
                    w_dec.csr_wr = ~(w_f3[1] && in_inst[19:15] == 5'd0);
                    w_imm32      = w_f3[2] ? {27'b0, in_inst[19:15]} : 32'b0;
                end
            end
            OP_MISC: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase

        w_dec.imm = XLEN'($signed(w_imm32));

        if (!w_legal) begin
            w_dec.rs1_en  = 1'b0;
            w_dec.rs2_en  = 1'b0;
            w_dec.rd_en   = 1'b0;
            w_dec.f3_en   = 1'b0;
            w_dec.f7_en   = 1'b0;
            w_dec.imm     = '0;
            w_dec.mem_en  = 1'b0;
            w_dec.mem_wr  = 1'b0;
            w_dec.csr_en  = 1'b0;
            w_dec.csr_wr  = 1'b0;
            w_dec.pc_load = 1'b0;
        end
        w_dec.illegal = ~w_legal;
        if (w_dec.rd == 5'd0) w_dec.rd_en = 1'b0;
    end

    // ---------------------------------------------------------------- buffer
    entry_t     r_e0, r_e1;
    logic [1:0] r_count;
    logic       r_in_ready;

    entry_t     w_new, w_c0, w_c1, w_n_e0, w_n_e1;
    logic       w_c0_v, w_c1_v, w_pop, w_push;
    logic [1:0] w_n_count;

    assign w_new  = '{tid: in_tid, pc: in_pc, dec: w_dec};
    assign w_pop  = (r_count != 2'd0) && out_ready;
    assign w_push = in_valid && r_in_ready && !(flush_valid && in_tid == flush_tid);

    always_comb begin
        // Entries left after the pop, before flush filtering.
        if (w_pop) begin
            w_c0   = r_e1;
            w_c0_v = (r_count == 2'd2);
            w_c1   = r_e1;
            w_c1_v = 1'b0;
        end else begin
            w_c0   = r_e0;
            w_c0_v = (r_count != 2'd0);
            w_c1   = r_e1;
            w_c1_v = (r_count == 2'd2);
        end
        if (flush_valid && w_c0.tid == flush_tid) w_c0_v = 1'b0;
        if (flush_valid && w_c1.tid == flush_tid) w_c1_v = 1'b0;

        // Compact survivors toward the head, then append the new entry.
        // Slots not rewritten hold their value, keeping the head stable.
        w_n_e0    = r_e0;
        w_n_e1    = r_e1;
        w_n_count = 2'd0;
        if (w_c0_v) begin
            w_n_e0 = w_c0;
            if (w_c1_v) begin
                w_n_e1    = w_c1;
                w_n_count = 2'd2;
            end else if (w_push) begin
                w_n_e1    = w_new;
                w_n_count = 2'd2;
            end else begin
                w_n_count = 2'd1;
            end
        end else if (w_c1_v) begin
            w_n_e0 = w_c1;
            if (w_push) begin
                w_n_e1    = w_new;
                w_n_count = 2'd2;
            end else begin
                w_n_count = 2'd1;
            end
        end else if (w_push) begin
            w_n_e0    = w_new;
            w_n_count = 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    // NOTE: both buffer slots are reset because the head drives the outputs,
    // which must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0       <= '0;
            r_e1       <= '0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_e0       <= w_n_e0;
            r_e1       <= w_n_e1;
            r_count    <= w_n_count;
            r_in_ready <= (w_n_count != 2'd2);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_count != 2'd0);
    assign out_tid     = r_e0.tid;
    assign out_pc      = r_e0.pc;
    assign out_opcode  = r_e0.dec.opcode;
    assign out_rs1     = r_e0.dec.rs1;
    assign out_rs2     = r_e0.dec.rs2;
    assign out_rd      = r_e0.dec.rd;
    assign out_rs1_en  = r_e0.dec.rs1_en;
    assign out_rs2_en  = r_e0.dec.rs2_en;
    assign out_rd_en   = r_e0.dec.rd_en;
    assign out_funct3  = r_e0.dec.funct3;
    assign out_f3_en   = r_e0.dec.f3_en;
    assign out_funct7  = r_e0.dec.funct7;
    assign out_f7_en   = r_e0.dec.f7_en;
    assign out_imm     = r_e0.dec.imm;
    assign out_mem_en  = r_e0.dec.mem_en;
    assign out_mem_wr  = r_e0.dec.mem_wr;
    assign out_csr_en  = r_e0.dec.csr_en;
    assign out_csr_wr  = r_e0.dec.csr_wr;
    assign out_pc_load = r_e0.dec.pc_load;
    assign out_illegal = r_e0.dec.illegal;

endmodule

// File: tb/tb_rv_decode_mt.sv
// Self-checking bench for rv_decode_mt: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_rv_decode_mt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_inst = '0;
    logic [1:0]  in_tid = '0;
    logic [31:0] in_pc = '0;
    logic        flush_valid = 1'b0;
    logic [1:0]  flush_tid = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [1:0]  out_tid;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic        out_rs1_en, out_rs2_en, out_rd_en, out_f3_en, out_f7_en;
    logic        out_mem_en, out_mem_wr, out_csr_en, out_csr_wr, out_pc_load, out_illegal;

    rv_decode_mt #(.NTHREADS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_tid(in_tid), .in_pc(in_pc),
        .flush_valid(flush_valid), .flush_tid(flush_tid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tid(out_tid), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_en(out_rd_en),
        .out_funct3(out_funct3), .out_f3_en(out_f3_en),
        .out_funct7(out_funct7), .out_f7_en(out_f7_en), .out_imm(out_imm),
        .out_mem_en(out_mem_en), .out_mem_wr(out_mem_wr),
        .out_csr_en(out_csr_en), .out_csr_wr(out_csr_wr),
        .out_pc_load(out_pc_load), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  tid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1_en, rs2_en, rd_en;
        logic [2:0]  funct3;
        logic        f3_en;
        logic [6:0]  funct7;
        logic        f7_en;
        logic [31:0] imm;
        logic        mem_en, mem_wr, csr_en, csr_wr, pc_load, illegal;
    } exp_t;

    exp_t w_dut;
    assign w_dut = {out_tid, out_pc, out_opcode, out_rs1, out_rs2, out_rd,
                    out_rs1_en, out_rs2_en, out_rd_en, out_funct3, out_f3_en,
                    out_funct7, out_f7_en, out_imm, out_mem_en, out_mem_wr,
                    out_csr_en, out_csr_wr, out_pc_load, out_illegal};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder: instruction format selects the immediate, a use
    // mask {rs1,rs2,rd,f3,f7} names the consumed fields, legality is separate.
    function automatic exp_t model(input logic [31:0] i, input logic [1:0] tid,
                                   input logic [31:0] pc);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  use_m;
        logic [31:0] imm;
        logic        ok;
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        e.tid = tid; e.pc = pc; e.opcode = i[6:0];
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        e.funct3 = f3; e.funct7 = f7;
        use_m = '0; imm = '0; ok = 1'b1;
        case (i[6:0])
            7'h37, 7'h17: begin use_m = 5'b00100; imm = i & 32'hFFFF_F000; end
            7'h6f: begin
                use_m = 5'b00100; e.pc_load = 1'b1;
                imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'h67: begin
                use_m = 5'b10110; e.pc_load = 1'b1;
                imm = 32'($signed(i[31:20])); ok = (f3 == 0);
            end
            7'h63: begin
                use_m = 5'b11010; e.pc_load = 1'b1;
                imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                ok = !(f3 == 2 || f3 == 3);
            end
            7'h03: begin
                use_m = 5'b10110; e.mem_en = 1'b1;
                imm = 32'($signed(i[31:20])); ok = (f3 != 3) && (f3 < 6);
            end
            7'h23: begin
                use_m = 5'b11010; e.mem_en = 1'b1; e.mem_wr = 1'b1;
                imm = 32'($signed({i[31:25], i[11:7]})); ok = (f3 < 3);
            end
            7'h13: begin
                use_m = 5'b10110;
                if (f3 == 1 || f3 == 5) begin
                    use_m[0] = 1'b1; imm = {27'b0, i[24:20]};
                    ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
                end else begin
                    imm = 32'($signed(i[31:20]));
                end
            end
            7'h33: begin
                use_m = 5'b11111;
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h73: begin
                if (f3 == 0) ok = (i == 32'h73) || (i == 32'h0010_0073);
                else if (f3 == 4) ok = 1'b0;
                else begin
                    use_m = {!f3[2], 1'b0, 1'b1, 1'b1, 1'b0};
                    e.csr_en = 1'b1;
                    e.csr_wr = !(f3[1] && i[19:15] == 0);
                    imm = f3[2] ? {27'b0, i[19:15]} : 32'b0;
                end
            end
            7'h0f: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        {e.rs1_en, e.rs2_en, e.rd_en, e.f3_en, e.f7_en} = use_m;
        e.imm = imm;
        if (e.rd == 0) e.rd_en = 1'b0;
        if (!ok) begin
            {e.rs1_en, e.rs2_en, e.rd_en, e.f3_en, e.f7_en} = '0;
            {e.mem_en, e.mem_wr, e.csr_en, e.csr_wr, e.pc_load} = '0;
            e.imm = '0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // Expected buffer contents, head at index 0.
    exp_t q[$];

    always @(posedge clk or negedge rst_n) begin : model_upd
        bit acc;
        if (!rst_n) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (flush_valid)
                for (int k = q.size() - 1; k >= 0; k--)
                    if (q[k].tid == flush_tid) q.delete(k);
            if (acc && !(flush_valid && in_tid == flush_tid))
                q.push_back(model(in_inst, in_tid, in_pc));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, q.size() < 2);
            if (q.size() != 0) check("head", w_dut, q[0]);
        end
    end

    // Called at a falling edge: apply inputs, wait through one rising edge.
    task automatic drive(input logic v, input logic [31:0] inst, input logic [1:0] tid,
                         input logic [31:0] pc, input logic ordy,
                         input logic fv, input logic [1:0] ftid);
        #1;
        in_valid = v; in_inst = inst; in_tid = tid; in_pc = pc;
        out_ready = ordy; flush_valid = fv; flush_tid = ftid;
        @(negedge clk);
    endtask

    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};

    initial begin
        logic [31:0] r;
        logic [31:0] s5 [5] = '{32'h0, 32'h0000_f033, 32'h4000_f033,
                               32'h0000_1073, 32'h0000_2073};
        logic        ill5 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst fields", w_dut, '0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Model pins
        check("model lui imm", model(32'h0000_50b7, 1, 0).imm, 32'h0000_5000);
        check("model beq imm", model(32'hfe00_0ce3, 0, 0).imm, 32'hFFFF_FFF8);
        check("model jal imm", model(32'hff9f_f2ef, 0, 0).imm, 32'hFFFF_FFF8);
        check("model bad f7", model(32'h4000_f033, 0, 0).illegal, 1'b1);
        check("model csrrs wr", model(32'h0000_2073, 0, 0).csr_wr, 1'b0);

        // LUI
        drive(1, 32'h0000_50b7, 1, 32'h100, 1, 0, 0);
        check("lui valid", out_valid, 1'b1);
        check("lui opcode", out_opcode, 7'b0110111);
        check("lui rd", {out_rd, out_rd_en}, {5'd1, 1'b1});
        check("lui imm", out_imm, 32'h0000_5000);
        check("lui tid", out_tid, 2'd1);
        check("lui others", {out_rs1_en, out_rs2_en, out_f3_en, out_f7_en, out_mem_en,
                             out_mem_wr, out_csr_en, out_csr_wr, out_pc_load, out_illegal}, '0);

        // Back-to-back addi, lw, beq, jal
        drive(1, 32'h0050_8193, 0, 32'h104, 1, 0, 0);
        check("addi", {out_rs1, out_rd, out_imm}, {5'd1, 5'd3, 32'd5});
        drive(1, 32'h0050_2083, 0, 32'h108, 1, 0, 0);
        check("lw", {out_mem_en, out_mem_wr, out_rd, out_imm}, {1'b1, 1'b0, 5'd1, 32'd5});
        drive(1, 32'hfe00_0ce3, 0, 32'h10c, 1, 0, 0);
        check("beq", {out_rs1_en, out_rs2_en, out_pc_load, out_rd_en, out_imm},
              {4'b1110, 32'hFFFF_FFF8});
        drive(1, 32'hff9f_f2ef, 0, 32'h110, 1, 0, 0);
        check("jal", {out_rd, out_pc_load, out_imm}, {5'd5, 1'b1, 32'hFFFF_FFF8});
        drive(0, 0, 0, 0, 1, 0, 0);
        check("drained", out_valid, 1'b0);

        // Backpressure: third push held, head stable, then in-order drain
        drive(1, 32'h0010_0093, 0, 32'h200, 0, 0, 0);
        drive(1, 32'h0020_0113, 1, 32'h204, 0, 0, 0);
        check("full in_ready", in_ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h0030_0193, 2, 32'h208, 0, 0, 0);
            check("stall head pc", out_pc, 32'h200);
        end
        drive(1, 32'h0030_0193, 2, 32'h208, 1, 0, 0);
        check("drain 2nd", out_pc, 32'h204);
        drive(1, 32'h0030_0193, 2, 32'h208, 1, 0, 0);
        check("drain 3rd", out_pc, 32'h208);
        drive(0, 0, 0, 0, 1, 0, 0);

        // Flush tid0 with tid0 incoming
        drive(1, 32'h0010_0093, 0, 32'h300, 0, 0, 0);
        drive(1, 32'h0020_0113, 2, 32'h304, 0, 0, 0);
        drive(1, 32'h0030_0193, 0, 32'h308, 0, 1, 0);
        check("flush head", {out_valid, out_tid, out_pc}, {1'b1, 2'd2, 32'h304});
        check("flush count", in_ready, 1'b1);
        drive(1, 32'h0030_0193, 0, 32'h30c, 0, 1, 0);
        check("flush drops push", {out_pc, in_ready}, {32'h304, 1'b1});
        drive(0, 0, 0, 0, 0, 1, 3);
        check("flush other tid", out_pc, 32'h304);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 2);
        check("flush empty", out_valid, 1'b0);

        // Illegal / CSR corner encodings
        for (int k = 0; k < 5; k++) begin
            drive(1, s5[k], 1, 32'h400 + 32'(4 * k), 1, 0, 0);
            check("illegal flag", out_illegal, ill5[k]);
            if (k == 3) check("csrrw x0", {out_csr_en, out_csr_wr, out_rd_en}, 3'b110);
            if (k == 4) check("csrrs x0", {out_csr_en, out_csr_wr}, 2'b10);
        end
        drive(0, 0, 0, 0, 1, 0, 0);

        // Asynchronous reset with two buffered entries
        drive(1, 32'h0010_0093, 1, 32'h500, 0, 0, 0);
        drive(1, 32'h0020_0113, 1, 32'h504, 0, 0, 0);
        #3 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("async rst valid", out_valid, 1'b0);
        check("async rst ready", in_ready, 1'b1);
        check("async rst fields", w_dut, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(1, 32'h0030_0193, 3, 32'h600, 0, 0, 0);
        check("post rst push", {out_valid, out_pc}, {1'b1, 32'h600});
        drive(0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) == 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if ($urandom_range(0, 15) == 0) r = $urandom_range(0, 1) ? 32'h73 : 32'h0010_0073;
            drive($urandom_range(0, 3) != 0, r, 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  2'($urandom_range(0, 3)));
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("final empty", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
